// File: rtl/switch_sched_rr_if.sv
// Bus bundle between the round-robin switch scheduler, the per-port input RAM
// read side and the per-port output RAM write ports.
interface switch_sched_rr_if #(
    parameter int NUM_PORTS = 3,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12
);
    logic [NUM_PORTS*DATA_W-1:0] in_data;
    logic [NUM_PORTS*ADDR_W-1:0] in_wr_addr;
    logic [NUM_PORTS*ADDR_W-1:0] in_rd_addr;
    logic [NUM_PORTS-1:0]        in_rden;
    logic [NUM_PORTS*DATA_W-1:0] out_data;
    logic [NUM_PORTS-1:0]        out_wr;

    modport master (
        input  in_data, in_wr_addr,
        output in_rd_addr, in_rden, out_data, out_wr
    );

    modport slave (
        output in_data, in_wr_addr,
        input  in_rd_addr, in_rden, out_data, out_wr
    );
endinterface

// File: rtl/switch_sched_rr.sv
// Drains NUM_PORTS input RAM queues into per-destination output writers with
// per-output round-robin arbitration; out-of-range destinations are dropped and counted.
module switch_sched_rr #(
    parameter int NUM_PORTS = 3,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 12,
    parameter int DEST_LSB  = 0,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    switch_sched_rr_if.master     bus,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  busy
);
    localparam int DEST_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int NCNT_W = $clog2(NUM_PORTS + 1);
    localparam logic [DEST_W:0] NP_W = (DEST_W + 1)'(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] rd_ptr      [NUM_PORTS];
    logic [DEST_W-1:0] rr_ptr      [NUM_PORTS];
    logic [DEST_W-1:0] rr_nxt_p0   [NUM_PORTS];
    logic [DATA_W-1:0] gnt_word_p0 [NUM_PORTS];
    logic [DATA_W-1:0] out_data_p1 [NUM_PORTS];
    logic [NUM_PORTS-1:0] out_wr_p1;
    logic [NUM_PORTS-1:0] nonempty, drop_p0, pop_p0, gnt_vld_p0;
    logic [NCNT_W-1:0]    n_drop_p0;

    function automatic logic [DEST_W-1:0] head_dest(input logic [DATA_W-1:0] w);
        return w[DEST_LSB +: DEST_W];
    endfunction

    function automatic logic dest_ok(input logic [DEST_W-1:0] d);
        return {1'b0, d} < NP_W;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [NCNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = enable ? FETCH : IDLE;
            FETCH:   state_nxt = enable ? ISSUE : IDLE;
            ISSUE:   state_nxt = enable ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: head classification and per-output round-robin grant search
    always_comb begin
        int idx;
        idx        = 0;
        nonempty   = '0;
        drop_p0    = '0;
        pop_p0     = '0;
        gnt_vld_p0 = '0;
        n_drop_p0  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            nonempty[i] = rd_ptr[i] != bus.in_wr_addr[i*ADDR_W +: ADDR_W];
            if (nonempty[i] && !dest_ok(head_dest(bus.in_data[i*DATA_W +: DATA_W])))
                drop_p0[i] = 1'b1;
            n_drop_p0 = n_drop_p0 + NCNT_W'(drop_p0[i]);
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            gnt_word_p0[o] = '0;
            rr_nxt_p0[o]   = rr_ptr[o];
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(rr_ptr[o]) + k;
                if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                if (!gnt_vld_p0[o] && nonempty[idx] &&
                    head_dest(bus.in_data[idx*DATA_W +: DATA_W]) == DEST_W'(o)) begin
                    gnt_vld_p0[o]  = 1'b1;
                    gnt_word_p0[o] = bus.in_data[idx*DATA_W +: DATA_W];
                    rr_nxt_p0[o]   = (idx == NUM_PORTS - 1) ? '0 : DEST_W'(idx + 1);
                    pop_p0[idx]    = 1'b1;
                end
            end
        end
        pop_p0 = pop_p0 | drop_p0;
    end

    // Stage p1: commit grants, pops and drops on the edge that ends ISSUE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            out_wr_p1  <= '0;
            drop_count <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                rd_ptr[i]      <= '0;
                rr_ptr[i]      <= '0;
                out_data_p1[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            out_wr_p1 <= '0;
            if (state == ISSUE) begin
                out_wr_p1  <= gnt_vld_p0;
                drop_count <= sat_add(drop_count, n_drop_p0);
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (pop_p0[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                    rr_ptr[i] <= rr_nxt_p0[i];
                    if (gnt_vld_p0[i]) out_data_p1[i] <= gnt_word_p0[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            bus.in_rd_addr[i*ADDR_W +: ADDR_W] = rd_ptr[i];
            bus.out_data[i*DATA_W +: DATA_W]   = out_data_p1[i];
        end
    end

    assign bus.out_wr  = out_wr_p1;
    assign bus.in_rden = {NUM_PORTS{state != IDLE}};
    // Gated by reset_n so busy drops together with every other output during reset
    assign busy        = reset_n & enable & (|nonempty);
endmodule

// File: tb/tb_switch_sched_rr.sv
// Randomized and directed bench for switch_sched_rr against a queue-based
// round-robin reference model with a registered-read RAM model per input.
module tb_switch_sched_rr;
    localparam int NP = 3;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int CW = 4;

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic [CW-1:0] drop_count;
    logic          busy;

    switch_sched_rr_if #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) sif ();

    switch_sched_rr #(
        .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .DEST_LSB(0), .CNT_W(CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .bus        (sif),
        .drop_count (drop_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [NP][1<<AW];
    logic [AW-1:0] wr_ptr [NP];

    // Input RAMs: one-cycle registered read
    always @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (!reset_n) sif.in_data[i*DW +: DW] <= '0;
            else if (sif.in_rden[i]) sif.in_data[i*DW +: DW] <= mem[i][sif.in_rd_addr[i*AW +: AW]];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mq [NP][$];
    int            rr_m [NP];
    logic [AW-1:0] exp_rd [NP];
    logic [CW-1:0] exp_drop;
    logic [DW-1:0] exp_out [NP];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dst(input logic [DW-1:0] w);
        return int'(w % 4);
    endfunction

    function automatic bit model_busy();
        for (int i = 0; i < NP; i++) if (mq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NP*DW-1:0] exp_out_bus();
        logic [NP*DW-1:0] r;
        for (int o = 0; o < NP; o++) r[o*DW +: DW] = exp_out[o];
        return r;
    endfunction

    function automatic logic [NP*AW-1:0] exp_rd_bus();
        logic [NP*AW-1:0] r;
        for (int i = 0; i < NP; i++) r[i*AW +: AW] = exp_rd[i];
        return r;
    endfunction

    task automatic model_round(output logic [NP-1:0] ewr);
        bit popq [NP];
        int q;
        ewr = '0;
        for (int i = 0; i < NP; i++) popq[i] = 1'b0;
        for (int o = 0; o < NP; o++) begin
            for (int k = 0; k < NP; k++) begin
                q = (rr_m[o] + k) % NP;
                if (mq[q].size() != 0 && dst(mq[q][0]) == o) begin
                    ewr[o]     = 1'b1;
                    exp_out[o] = mq[q][0];
                    popq[q]    = 1'b1;
                    rr_m[o]    = (q + 1) % NP;
                    break;
                end
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (mq[i].size() != 0 && dst(mq[i][0]) >= NP) begin
                popq[i] = 1'b1;
                if (exp_drop != {CW{1'b1}}) exp_drop = exp_drop + 1'b1;
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (popq[i]) begin
                void'(mq[i].pop_front());
                exp_rd[i] = exp_rd[i] + 1'b1;
            end
        end
    endtask

    task automatic push_word(input int q, input logic [DW-1:0] w);
        mem[q][wr_ptr[q]] = w;
        wr_ptr[q] = wr_ptr[q] + 1'b1;
        sif.in_wr_addr[q*AW +: AW] = wr_ptr[q];
        mq[q].push_back(w);
    endtask

    task automatic push_rand(input int q, input int d);
        logic [DW-1:0] w;
        w = $urandom;
        w = (w & ~32'h3) | 32'(d);
        push_word(q, w);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NP; i++) begin
            mq[i].delete();
            rr_m[i]    = 0;
            exp_rd[i]  = '0;
            exp_out[i] = '0;
            wr_ptr[i]  = '0;
            sif.in_wr_addr[i*AW +: AW] = '0;
        end
        exp_drop = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Enable from IDLE, then one model round per ISSUE until every queue drains
    task automatic run_burst(input int pause_at);
        logic [NP-1:0] ewr;
        int r;
        r = 0;
        enable = 1'b1;
        @(posedge clk); #1;
        check("rden_on", sif.in_rden, {NP{1'b1}});
        while (model_busy() && r < 6000) begin
            @(posedge clk); #1;
            check("wr_gap", sif.out_wr, '0);
            @(posedge clk); #1;
            model_round(ewr);
            r++;
            check("out_wr", sif.out_wr, ewr);
            check("out_data", sif.out_data, exp_out_bus());
            check("rd_addr", sif.in_rd_addr, exp_rd_bus());
            check("drop_cnt", drop_count, exp_drop);
            check("busy", busy, model_busy());
            if (r == pause_at && model_busy()) begin
                enable = 1'b0;
                #1 check("busy_paused", busy, 1'b0);
                @(posedge clk); #1;
                check("rden_off", sif.in_rden, '0);
                repeat (3) @(posedge clk);
                #1;
                check("rd_frozen", sif.in_rd_addr, exp_rd_bus());
                check("wr_paused", sif.out_wr, '0);
                enable = 1'b1;
                @(posedge clk); #1;
                check("rden_resume", sif.in_rden, {NP{1'b1}});
            end
        end
        check("busy_end", busy, 1'b0);
        enable = 1'b0;
        @(posedge clk); #1;
        check("rden_idle", sif.in_rden, '0);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        sif.in_wr_addr = '0;
        do_reset();
        #1;
        check("rst_rd", sif.in_rd_addr, '0);
        check("rst_rden", sif.in_rden, '0);
        check("rst_wr", sif.out_wr, '0);
        check("rst_data", sif.out_data, '0);
        check("rst_drop", drop_count, '0);
        check("rst_busy", busy, 1'b0);

        // Single word to output 1
        push_word(0, 32'h0000_0005);
        run_burst(-1);
        check("t1_data", sif.out_data[DW +: DW], 32'h5);
        check("t1_rd0", sif.in_rd_addr[0 +: AW], 12'h001);
        check("t1_busy", busy, 1'b0);

        // Three-way contention on output 2
        for (int j = 0; j < 2; j++)
            for (int q = 0; q < NP; q++) push_word(q, 32'h100 * (j * NP + q + 1) + 32'h2);
        run_burst(-1);

        // Out-of-range destination
        do_reset();
        push_word(1, 32'h0000_0003);
        run_burst(-1);
        check("t3_drop", drop_count, 4'd1);
        check("t3_rd1", sif.in_rd_addr[AW +: AW], 12'h001);
        check("t3_wr", sif.out_wr, '0);

        // Contention on output 1 with enable withdrawn during FETCH
        push_word(0, 32'hA001); push_word(0, 32'hA005);
        push_word(1, 32'hB001); push_word(1, 32'hB005);
        push_word(2, 32'hC001);
        run_burst(1);

        // Randomized bursts
        for (int b = 0; b < 10; b++) begin
            for (int q = 0; q < NP; q++)
                for (int j = 0; j < int'($urandom_range(0, 6)); j++)
                    push_rand(q, int'($urandom_range(0, 3)));
            run_burst(int'($urandom_range(0, 4)));
        end

        // Asynchronous reset in the middle of ISSUE
        push_word(0, 32'hD001); push_word(1, 32'hD101); push_word(2, 32'hD203);
        enable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 reset_n = 1'b0;
        #1;
        check("arst_rd", sif.in_rd_addr, '0);
        check("arst_rden", sif.in_rden, '0);
        check("arst_wr", sif.out_wr, '0);
        check("arst_data", sif.out_data, '0);
        check("arst_drop", drop_count, '0);
        check("arst_busy", busy, 1'b0);
        enable = 1'b0;
        clear_model();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Pointer wrap-around and drop counter saturation
        for (int j = 0; j < (1 << AW) - 1; j++) push_rand(0, j % 4);
        run_burst(-1);
        check("wrap_pre", sif.in_rd_addr[0 +: AW], 12'hFFF);
        check("drop_sat", drop_count, 4'hF);
        push_word(0, 32'h0000_0010);
        run_burst(-1);
        check("wrap_rd", sif.in_rd_addr[0 +: AW], 12'h000);
        check("wrap_data", sif.out_data[0 +: DW], 32'h10);
        check("wrap_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
